// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: memory widths, funct3 codes, FSM states and the
// accept-time access legality check.
package lsu_pkg;

    localparam int unsigned MEM_ADDR_WIDTH     = 10;
    localparam int unsigned MEM_DATA_WIDTH     = 32;
    localparam int unsigned MEM_TRANSFER_WIDTH = MEM_DATA_WIDTH / 8;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    // Accept-to-response latencies in clock edges.
    localparam int unsigned LSU_LAT_ERR   = 1;
    localparam int unsigned LSU_LAT_STORE = 2;
    localparam int unsigned LSU_LAT_LOAD  = 3;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StRdWait,
        StResp
    } lsu_state_e;

    // Misaligned, unsupported funct3 for the direction, or beyond the memory's address range.
    function automatic logic lsu_access_err(input logic        store,
                                            input logic [2:0]  funct3,
                                            input logic [31:0] addr,
                                            input int unsigned addr_width);
        logic bad;
        bad = (addr >> addr_width) != 32'd0;
        case (funct3)
            F3_B:    bad = bad;
            F3_H:    bad = bad | addr[0];
            F3_W:    bad = bad | (addr[1:0] != 2'b00);
            F3_BU:   bad = bad | store;
            F3_HU:   bad = bad | store | addr[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Shifts the fetched word down to the accessed byte lane and sign-/zero-extends it per funct3.
module lsu_load_align
    import lsu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = MEM_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] rdata_i,
    input  logic [1:0]            offset_i,
    input  logic [2:0]            funct3_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] shifted;

    always_comb begin
        shifted = rdata_i >> {offset_i, 3'b000};
        case (funct3_i)
            F3_B:    rdata_o = {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
            F3_BU:   rdata_o = {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]};
            F3_H:    rdata_o = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
            F3_HU:   rdata_o = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
            default: rdata_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator for the single-port data memory: one request per handshake, registered
// memory-side outputs, aligned/extended read data and an error flag for illegal accesses.
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = MEM_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH     = MEM_DATA_WIDTH,
    parameter int unsigned TRANSFER_WIDTH = MEM_TRANSFER_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_i,
    output logic                      ready_o,
    input  logic                      store_i,
    input  logic [2:0]                funct3_i,
    input  logic [31:0]               addr_i,
    input  logic [31:0]               wdata_i,
    output logic                      rsp_valid_o,
    output logic [31:0]               rdata_o,
    output logic                      err_o,
    output logic                      mem_we_o,
    output logic [ADDR_WIDTH-1:0]     mem_addr_o,
    output logic [DATA_WIDTH-1:0]     mem_wdata_o,
    output logic [TRANSFER_WIDTH-1:0] mem_strb_o,
    input  logic [DATA_WIDTH-1:0]     mem_rdata_i
);

    lsu_state_e state_q;
    logic       store_q;
    logic [2:0] funct3_q;
    logic [1:0] offset_q;

    logic                      err_d;
    logic [TRANSFER_WIDTH-1:0] strb_d;
    logic [DATA_WIDTH-1:0]     wdata_d;
    logic [DATA_WIDTH-1:0]     align_rdata;

    // Strobes are never zero for a store: dataMem reads a zero strobe as a full-word write.
    always_comb begin
        err_d   = lsu_access_err(store_i, funct3_i, addr_i, ADDR_WIDTH);
        strb_d  = '0;
        wdata_d = '0;
        case (funct3_i[1:0])
            2'd0: begin
                strb_d  = TRANSFER_WIDTH'(4'b0001 << addr_i[1:0]);
                wdata_d = DATA_WIDTH'({4{wdata_i[7:0]}});
            end
            2'd1: begin
                strb_d  = TRANSFER_WIDTH'(4'b0011 << addr_i[1:0]);
                wdata_d = DATA_WIDTH'({2{wdata_i[15:0]}});
            end
            default: begin
                strb_d  = '1;
                wdata_d = DATA_WIDTH'(wdata_i);
            end
        endcase
    end

    lsu_load_align #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_load_align (
        .rdata_i  (mem_rdata_i),
        .offset_i (offset_q),
        .funct3_i (funct3_q),
        .rdata_o  (align_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            ready_o     <= 1'b1;
            rsp_valid_o <= 1'b0;
            rdata_o     <= '0;
            err_o       <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            mem_strb_o  <= '0;
            store_q     <= 1'b0;
            funct3_q    <= '0;
            offset_q    <= '0;
        end else begin
            rsp_valid_o <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (req_i) begin
                        store_q  <= store_i;
                        funct3_q <= funct3_i;
                        offset_q <= addr_i[1:0];
                        rdata_o  <= '0;
                        ready_o  <= 1'b0;
                        if (err_d) begin
                            err_o       <= 1'b1;
                            rsp_valid_o <= 1'b1;
                            state_q     <= StResp;
                        end else begin
                            err_o       <= 1'b0;
                            mem_addr_o  <= addr_i[ADDR_WIDTH-1:0];
                            mem_we_o    <= store_i;
                            mem_strb_o  <= store_i ? strb_d : '0;
                            mem_wdata_o <= store_i ? wdata_d : '0;
                            state_q     <= StAccess;
                        end
                    end
                end
                StAccess: begin
                    mem_we_o    <= 1'b0;
                    mem_strb_o  <= '0;
                    mem_addr_o  <= '0;
                    mem_wdata_o <= '0;
                    if (store_q) begin
                        rsp_valid_o <= 1'b1;
                        state_q     <= StResp;
                    end else begin
                        state_q <= StRdWait;
                    end
                end
                StRdWait: begin
                    rdata_o     <= align_rdata;
                    rsp_valid_o <= 1'b1;
                    state_q     <= StResp;
                end
                default: begin
                    ready_o <= 1'b1;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
